// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter sequencer with absolute jump, signed relative
// branch, call/return through an internal return-address stack, fetch stall,
// halt-address detection and sticky stack-error halting. All outputs are
// registered; the next state is formed combinationally from registered state
// and the current enables, then captured on the rising edge of CLK.
module pc_ctrl #(
  parameter int PW        = 10,
  parameter int OW        = 8,
  parameter int RAS_DEPTH = 4,
  parameter int HALT_PC   = 85,
  parameter int RESET_PC  = 0
) (
  input  logic                           CLK,
  input  logic                           init_n,
  input  logic                           stall,
  input  logic                           jump_en,
  input  logic                           branch_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic [PW-1:0]                  destination,
  input  logic [OW-1:0]                  offset,
  output logic [PW-1:0]                  pc,
  output logic                           halt,
  output logic                           ras_err,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int SW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  // Halt threshold held 32 bits wide so a value beyond the PC range
  // (e.g. 2**PW) simply never matches instead of being truncated.
  localparam logic [31:0]   HALT_V   = 32'(HALT_PC);
  localparam logic [PW-1:0] RESET_V  = PW'(RESET_PC);
  localparam logic [PW-1:0] ONE_PC   = PW'(1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [PW-1:0] pc_r;
  logic          halt_r;
  logic          err_r;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] stack_r [RAS_DEPTH];

  logic [PW-1:0] pc_next_s;
  logic          halt_next_s;
  logic          err_next_s;
  logic [CW-1:0] cnt_next_s;
  logic          push_s;
  logic [CW-1:0] top_cnt_s;
  logic [SW-1:0] top_idx_s;
  logic [SW-1:0] push_idx_s;
  logic [PW-1:0] pc_inc_s;
  logic [PW-1:0] branch_tgt_s;
  logic          at_halt_s;

  // Offset is two's-complement; the size cast of a signed value sign-extends
  // (or truncates when OW exceeds PW). Both sums wrap modulo 2**PW.
  assign pc_inc_s     = pc_r + ONE_PC;
  assign branch_tgt_s = pc_r + PW'($signed(offset));
  assign at_halt_s    = (32'(pc_r) >= HALT_V);

  // Stack indices: top of stack for a pop, next free slot for a push. The
  // push index is used only when cnt_r < RAS_DEPTH, so truncation is safe.
  assign top_cnt_s  = cnt_r - ONE_CNT;
  assign top_idx_s  = top_cnt_s[SW-1:0];
  assign push_idx_s = cnt_r[SW-1:0];

  // Next-state selection, highest priority first: halted, stalled,
  // halt-address reached, ret, call, jump, branch, sequential increment.
  always_comb begin
    pc_next_s   = pc_r;
    halt_next_s = halt_r;
    err_next_s  = err_r;
    cnt_next_s  = cnt_r;
    push_s      = 1'b0;
    if (halt_r || stall) begin
      pc_next_s = pc_r;
    end else if (at_halt_s) begin
      halt_next_s = 1'b1;
    end else if (ret_en) begin
      if (cnt_r != ZERO_CNT) begin
        pc_next_s  = stack_r[top_idx_s];
        cnt_next_s = top_cnt_s;
      end else begin
        err_next_s  = 1'b1;
        halt_next_s = 1'b1;
      end
    end else if (call_en) begin
      if (cnt_r < FULL_CNT) begin
        push_s     = 1'b1;
        cnt_next_s = cnt_r + ONE_CNT;
        pc_next_s  = destination;
      end else begin
        err_next_s  = 1'b1;
        halt_next_s = 1'b1;
      end
    end else if (jump_en) begin
      pc_next_s = destination;
    end else if (branch_en) begin
      pc_next_s = branch_tgt_s;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // Architectural state: PC, sticky halt and error flags, stack occupancy.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      pc_r   <= RESET_V;
      halt_r <= 1'b0;
      err_r  <= 1'b0;
      cnt_r  <= ZERO_CNT;
    end else begin
      pc_r   <= pc_next_s;
      halt_r <= halt_next_s;
      err_r  <= err_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  // Return-address storage; contents are don't-care after reset, so the
  // array carries no reset and is written only on a successful call.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      stack_r[push_idx_s] <= pc_inc_s;
    end else begin
      stack_r[push_idx_s] <= stack_r[push_idx_s];
    end
  end

  assign pc        = pc_r;
  assign halt      = halt_r;
  assign ras_err   = err_r;
  assign ras_count = cnt_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl. Two instances: dut_a uses the default parameters
// (RAS_DEPTH=4, HALT_PC=85); dut_b uses RAS_DEPTH=2 and HALT_PC=1024 so the
// PC can wrap and the stack can overflow. Stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares them.
module tb_pc_ctrl;

  logic       CLK = 1'b0;
  logic       a_init_n, a_stall, a_jump, a_branch, a_call, a_ret;
  logic [9:0] a_dest;
  logic [7:0] a_off;
  logic [9:0] a_pc;
  logic       a_halt, a_err;
  logic [2:0] a_cnt;
  logic       b_init_n, b_stall, b_jump, b_branch, b_call, b_ret;
  logic [9:0] b_dest;
  logic [7:0] b_off;
  logic [9:0] b_pc;
  logic       b_halt, b_err;
  logic [1:0] b_cnt;

  typedef struct {
    int         sel;
    logic [9:0] pc;
    logic       halt;
    logic       err;
    logic [2:0] cnt;
    string      name;
  } exp_t;

  exp_t q[$];
  event mon_ev;
  int   checks = 0;
  int   errors = 0;

  // Enable vector layout: {stall, ret, call, jump, branch}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] BR = 5'b00001;
  localparam logic [4:0] JP = 5'b00010;
  localparam logic [4:0] CL = 5'b00100;
  localparam logic [4:0] RT = 5'b01000;
  localparam logic [4:0] ST = 5'b10000;

  pc_ctrl dut_a (
    .CLK(CLK), .init_n(a_init_n), .stall(a_stall), .jump_en(a_jump),
    .branch_en(a_branch), .call_en(a_call), .ret_en(a_ret),
    .destination(a_dest), .offset(a_off), .pc(a_pc), .halt(a_halt),
    .ras_err(a_err), .ras_count(a_cnt)
  );

  pc_ctrl #(.PW(10), .OW(8), .RAS_DEPTH(2), .HALT_PC(1024), .RESET_PC(0)) dut_b (
    .CLK(CLK), .init_n(b_init_n), .stall(b_stall), .jump_en(b_jump),
    .branch_en(b_branch), .call_en(b_call), .ret_en(b_ret),
    .destination(b_dest), .offset(b_off), .pc(b_pc), .halt(b_halt),
    .ras_err(b_err), .ras_count(b_cnt)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  always #5 CLK = ~CLK;

  // Monitor: compare one queued expectation per falling edge, or at once
  // when an asynchronous-reset check is signalled.
  always begin
    exp_t e;
    logic [9:0] apc;
    logic       ah, ae;
    logic [2:0] ac;
    @(negedge CLK or mon_ev);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel == 0) begin
        apc = a_pc; ah = a_halt; ae = a_err; ac = a_cnt;
      end else begin
        apc = b_pc; ah = b_halt; ae = b_err; ac = {1'b0, b_cnt};
      end
      checks = checks + 1;
      if (apc !== e.pc || ah !== e.halt || ae !== e.err || ac !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL %s: got pc=%0d halt=%b err=%b cnt=%0d, want pc=%0d halt=%b err=%b cnt=%0d",
                 e.name, apc, ah, ae, ac, e.pc, e.halt, e.err, e.cnt);
      end
    end
  end

  task automatic push_exp(input int sel, input logic [9:0] epc, input logic eh,
                          input logic ee, input logic [2:0] ec, input string nm);
    exp_t e;
    e.sel = sel; e.pc = epc; e.halt = eh; e.err = ee; e.cnt = ec; e.name = nm;
    q.push_back(e);
  endtask

  // One clock of stimulus on the selected instance; the other sees no enables.
  task automatic step(input int sel, input logic [4:0] en, input logic [9:0] dest,
                      input logic [7:0] off, input logic [9:0] epc, input logic eh,
                      input logic ee, input logic [2:0] ec, input string nm);
    a_stall = 1'b0; a_ret = 1'b0; a_call = 1'b0; a_jump = 1'b0; a_branch = 1'b0;
    b_stall = 1'b0; b_ret = 1'b0; b_call = 1'b0; b_jump = 1'b0; b_branch = 1'b0;
    if (sel == 0) begin
      {a_stall, a_ret, a_call, a_jump, a_branch} = en;
      a_dest = dest; a_off = off;
    end else begin
      {b_stall, b_ret, b_call, b_jump, b_branch} = en;
      b_dest = dest; b_off = off;
    end
    @(posedge CLK);
    #1;
    push_exp(sel, epc, eh, ee, ec, nm);
  endtask

  // Assert reset away from any edge, check the reset state before the next
  // rising edge, then release just after a falling edge.
  task automatic do_reset(input int sel, input string nm);
    @(negedge CLK);
    #1;
    if (sel == 0) a_init_n = 1'b0; else b_init_n = 1'b0;
    #1;
    push_exp(sel, 10'd0, 1'b0, 1'b0, 3'd0, nm);
    ->mon_ev;
    @(negedge CLK);
    #1;
    if (sel == 0) a_init_n = 1'b1; else b_init_n = 1'b1;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_init_n = 1'b0; b_init_n = 1'b0;
    a_stall = 1'b0; a_ret = 1'b0; a_call = 1'b0; a_jump = 1'b0; a_branch = 1'b0;
    b_stall = 1'b0; b_ret = 1'b0; b_call = 1'b0; b_jump = 1'b0; b_branch = 1'b0;
    a_dest = 10'd0; a_off = 8'd0; b_dest = 10'd0; b_off = 8'd0;

    // Instance A: reset, increment, branch/jump, call/return, priority, stall
    do_reset(0, "reset_a");
    for (int i = 1; i <= 5; i++) step(0, NO, 10'd0, 8'd0, 10'(i), 1'b0, 1'b0, 3'd0, "increment");
    step(0, JP, 10'd20, 8'd0,   10'd20, 1'b0, 1'b0, 3'd0, "jump_20");
    step(0, BR, 10'd0,  8'hFC,  10'd16, 1'b0, 1'b0, 3'd0, "branch_minus4");
    step(0, JP, 10'd50, 8'd0,   10'd50, 1'b0, 1'b0, 3'd0, "jump_50");
    step(0, JP, 10'd10, 8'd0,   10'd10, 1'b0, 1'b0, 3'd0, "jump_10");
    step(0, CL, 10'd40, 8'd0,   10'd40, 1'b0, 1'b0, 3'd1, "call_40");
    step(0, NO, 10'd0,  8'd0,   10'd41, 1'b0, 1'b0, 3'd1, "inc_41");
    step(0, CL, 10'd60, 8'd0,   10'd60, 1'b0, 1'b0, 3'd2, "call_60");
    step(0, RT, 10'd0,  8'd0,   10'd42, 1'b0, 1'b0, 3'd1, "ret_42");
    step(0, RT, 10'd0,  8'd0,   10'd11, 1'b0, 1'b0, 3'd0, "ret_11");
    step(0, CL | JP | BR, 10'd30, 8'd5, 10'd30, 1'b0, 1'b0, 3'd1, "call_wins");
    step(0, ST | RT, 10'd0, 8'd0, 10'd30, 1'b0, 1'b0, 3'd1, "stall_ret_held");
    step(0, RT, 10'd0,  8'd0,   10'd12, 1'b0, 1'b0, 3'd0, "ret_after_stall");
    step(0, ST, 10'd0,  8'd0,   10'd12, 1'b0, 1'b0, 3'd0, "stall_hold");
    step(0, NO, 10'd0,  8'd0,   10'd13, 1'b0, 1'b0, 3'd0, "resume_inc");
    step(0, RT, 10'd0,  8'd0,   10'd13, 1'b1, 1'b1, 3'd0, "underflow");
    step(0, JP, 10'd50, 8'd0,   10'd13, 1'b1, 1'b1, 3'd0, "err_halt_frozen");
    step(0, ST, 10'd0,  8'd0,   10'd13, 1'b1, 1'b1, 3'd0, "stall_in_halt");
    do_reset(0, "async_reset_clears");

    // Instance A: halt-address detection takes precedence over a call
    step(0, JP, 10'd84, 8'd0,   10'd84, 1'b0, 1'b0, 3'd0, "jump_84");
    step(0, NO, 10'd0,  8'd0,   10'd85, 1'b0, 1'b0, 3'd0, "reach_85");
    step(0, CL, 10'd40, 8'd0,   10'd85, 1'b1, 1'b0, 3'd0, "halt_over_call");
    step(0, JP, 10'd10, 8'd0,   10'd85, 1'b1, 1'b0, 3'd0, "halt_frozen");
    do_reset(0, "reset_after_halt");

    // Instance B: wrap, pushed pc+1 wrap, overflow, underflow after reset
    do_reset(1, "reset_b");
    step(1, JP, 10'd1023, 8'd0, 10'd1023, 1'b0, 1'b0, 3'd0, "jump_1023");
    step(1, NO, 10'd0,  8'd0,   10'd0,    1'b0, 1'b0, 3'd0, "wrap_to_0");
    step(1, BR, 10'd0,  8'hFC,  10'd1020, 1'b0, 1'b0, 3'd0, "branch_wrap");
    step(1, JP, 10'd1023, 8'd0, 10'd1023, 1'b0, 1'b0, 3'd0, "jump_1023b");
    step(1, CL, 10'd5,  8'd0,   10'd5,    1'b0, 1'b0, 3'd1, "call_at_top");
    step(1, RT, 10'd0,  8'd0,   10'd0,    1'b0, 1'b0, 3'd0, "ret_wrapped");
    step(1, CL, 10'd100, 8'd0,  10'd100,  1'b0, 1'b0, 3'd1, "call_100");
    step(1, CL, 10'd200, 8'd0,  10'd200,  1'b0, 1'b0, 3'd2, "call_200");
    step(1, CL, 10'd300, 8'd0,  10'd200,  1'b1, 1'b1, 3'd2, "overflow");
    step(1, RT, 10'd0,  8'd0,   10'd200,  1'b1, 1'b1, 3'd2, "overflow_frozen");
    do_reset(1, "reset_b2");
    step(1, RT, 10'd0,  8'd0,   10'd0,    1'b1, 1'b1, 3'd0, "underflow_b");

    @(negedge CLK);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter sequencer for the CSE141L core, replacing the fixed 10-bit PC. It issues the fetch address each cycle and supports:
- absolute jumps and signed relative branches,
- subroutine call/return through an internal return-address stack (RAS),
- fetch stall,
- a configurable halt address and sticky error halting.

It sits between the control decoder and instruction memory.

## Interface
Parameters:
- PW, 10, PC / address width in bits
- OW, 8, width of signed branch offset
- RAS_DEPTH, 4, return-address stack entries (≥1)
- HALT_PC, 85, PC value at or above which execution halts
- RESET_PC, 0, PC value after reset

Ports:
- CLK  input  1  clock, rising edge
- init_n  input  1  reset, asynchronous, active-low
- stall  input  1  hold PC and stack this cycle
- jump_en  input  1  absolute jump to destination
- branch_en  input  1  relative branch: pc + sign-extended offset
- call_en  input  1  push pc+1, then go to destination
- ret_en  input  1  pop stack top into PC
- destination  input  PW  jump/call target
- offset  input  OW  signed (two's-complement) branch offset
- pc  output  PW  current fetch address
- halt  output  1  sticky; program halted
- ras_err  output  1  sticky; stack overflow or underflow occurred
- ras_count  output  $clog2(RAS_DEPTH+1)  live stack occupancy

## Operation
- All state updates on the rising edge of CLK.
- init_n low forces the following immediately, independent of CLK:
  - pc=RESET_PC
  - halt=0
  - ras_err=0
  - ras_count=0
  - stack contents don't-care
- Per-cycle priority, highest first:
  1. halt=1: everything frozen (pc, stack, count); all enables ignored.
  2. stall=1: everything frozen.
  3. ret_en:
     - If count>0: pc<=stack[count-1], count-1.
     - If count==0 (underflow): pc unchanged, ras_err<=1, halt<=1.
  4. call_en:
     - If count<RAS_DEPTH: stack[count]<=pc+1, count+1, pc<=destination.
     - If count==RAS_DEPTH (overflow): pc unchanged, ras_err<=1, halt<=1. The stack is not overwritten.
  5. jump_en: pc<=destination.
  6. branch_en: pc<=pc + sign_extend(offset) mod 2^PW.
  7. Otherwise: pc<=pc+1 mod 2^PW.
- Only the highest-priority asserted enable acts; the others are dropped, not queued.
- Halt detection: if not halted and not stalled and pc ≥ HALT_PC, then halt<=1 and pc is held. The pc ≥ HALT_PC check takes precedence over items 3–7 in that cycle.
- All arithmetic is unsigned PW-bit and wraps silently, e.g. pc=2^PW-1 increments to 0. Wrap is not an error.
- pc+1 pushed by call wraps the same way.
- ras_err is set only by overflow or underflow and clears only on reset.

## Timing
- Latency is 1 cycle: an enable sampled at edge N gives the new pc visible after edge N.
- No combinational path from inputs to outputs; pc, halt, ras_err and ras_count are all registered.
- halt rises the cycle after pc ≥ HALT_PC is sampled. pc holds that value thereafter.
- Error halt: halt and ras_err rise together one edge after the offending call/ret.
- Reset assertion mid-operation takes effect asynchronously.
- Reset deassertion: the first update occurs on the first rising edge with init_n high. Upstream synchronises the release.
- stall during halt has no effect. Releasing stall resumes from the held pc with no lost or repeated increment.

## Test plan
- Reset/increment: RESET_PC=0; release init_n, no enables for 5 edges -> pc=1,2,3,4,5; halt=0, ras_count=0.
- Branch/jump/wrap, PW=10:
  - pc=20, branch_en, offset=-4 (8'hFC) -> pc=16.
  - pc=16, jump_en, destination=50 -> pc=50.
  - pc=1023, HALT_PC=1024 -> pc=0 next edge.
- Call/return nesting:
  - call at pc=10 to 40 -> pc=40, count=1.
  - call at pc=41 to 60 -> pc=60, count=2.
  - ret -> pc=42, count=1.
  - ret -> pc=11, count=0.
- Overflow/underflow:
  - RAS_DEPTH=2, third call -> pc unchanged, halt=1, ras_err=1, count=2.
  - After reset, ret with count 0 -> halt=1, ras_err=1.
- Priority/stall:
  - call_en+jump_en+branch_en together -> call wins.
  - stall with ret_en -> pc and count unchanged; ret_en sampled the next cycle with stall low executes the pop.
- Halt/reset: run to pc=85 with HALT_PC=85 -> halt=1 next edge, pc frozen despite jump_en. Pulsing init_n low asynchronously -> pc=0, halt=0, ras_err=0 before the next edge.
